// File: rtl/fifo_rd_checker.sv
// Read-side consumer/checker for the 16-bit-write / 32-bit-read FIFO demo.
// Optional first-mismatch capture is enabled by defining RD_CHECKER_ERR_CAPTURE_EN.
module fifo_rd_checker #(
   parameter logic [15:0] FIRST_VALUE = 16'h0001,
   parameter int unsigned BURST_LEN   = 16,
   parameter int unsigned GAP_CYCLES  = 4,
   parameter int unsigned TIMEOUT     = 64
) (
   input  logic        rd_clk_i,
   input  logic        a_rst_i,
   input  logic        enable_i,
   input  logic        pause_i,
   input  logic        rst_busy_i,
   input  logic        trigger_i,
   input  logic        empty_i,
   input  logic [31:0] rdata_i,
   input  logic        rd_valid_i,
   output logic        rd_en_o,
   output logic        busy_o,
   output logic        error_o,
   output logic        timeout_o,
   output logic [15:0] err_count_o,
   output logic [31:0] word_count_o,
   output logic [31:0] first_exp_o,
   output logic [31:0] first_act_o
);

   typedef enum logic [1:0] {IDLE, ARM, READ, GAP} state_t;

   state_t      state, state_nxt;
   logic [15:0] burst_cnt;
   logic [15:0] gap_cnt;
   logic [4:0]  outstanding;
   logic [15:0] to_cnt;
   logic [15:0] exp_half;
   logic [31:0] exp_word;
   logic        mismatch;
   logic        burst_done;
   logic        gap_done;

   always_comb begin
      rd_en_o    = (state == READ) & ~empty_i & ~pause_i & enable_i & ~rst_busy_i;
      busy_o     = (state == READ) | (state == GAP);
      burst_done = (BURST_LEN != 0) && rd_en_o &&
                   ({16'd0, burst_cnt} == BURST_LEN - 32'd1);
      gap_done   = ({16'd0, gap_cnt} == GAP_CYCLES - 32'd1);
      exp_word   = {exp_half, exp_half + 16'd1};
      mismatch   = rd_valid_i && (rdata_i != exp_word);
   end

   always_comb begin
      state_nxt = state;
      if (rst_busy_i || !enable_i) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE:    state_nxt = ARM;
            ARM:     if (trigger_i)  state_nxt = READ;
            READ:    if (burst_done) state_nxt = GAP;
            GAP:     if (gap_done)   state_nxt = READ;
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge rd_clk_i or posedge a_rst_i) begin
      if (a_rst_i) begin
         state     <= IDLE;
         burst_cnt <= '0;
         gap_cnt   <= '0;
      end else begin
         state <= state_nxt;
         if (state == READ && state_nxt == READ) begin
            if (rd_en_o) burst_cnt <= burst_cnt + 16'd1;
         end else begin
            burst_cnt <= '0;
         end
         if (state == GAP && state_nxt == GAP) gap_cnt <= gap_cnt + 16'd1;
         else                                  gap_cnt <= '0;
      end
   end

   // Checker state is independent of the FSM: late data arriving in IDLE is still checked.
   always_ff @(posedge rd_clk_i or posedge a_rst_i) begin
      if (a_rst_i) begin
         exp_half     <= FIRST_VALUE;
         word_count_o <= '0;
         err_count_o  <= '0;
         error_o      <= 1'b0;
         timeout_o    <= 1'b0;
         outstanding  <= '0;
         to_cnt       <= '0;
      end else begin
         if (rd_valid_i) begin
            exp_half     <= exp_half + 16'd2;
            word_count_o <= word_count_o + 32'd1;
            if (mismatch) begin
               error_o <= 1'b1;
               if (err_count_o != 16'hFFFF) err_count_o <= err_count_o + 16'd1;
            end
         end
         case ({rd_en_o, rd_valid_i && (outstanding != '0)})
            2'b10:   outstanding <= outstanding + 5'd1;
            2'b01:   outstanding <= outstanding - 5'd1;
            default: outstanding <= outstanding;
         endcase
         if (outstanding != '0 && !rd_valid_i) begin
            if ({16'd0, to_cnt} == TIMEOUT - 32'd1) begin
               timeout_o <= 1'b1;
               error_o   <= 1'b1;
               to_cnt    <= '0;
            end else begin
               to_cnt <= to_cnt + 16'd1;
            end
         end else begin
            to_cnt <= '0;
         end
      end
   end

`ifdef RD_CHECKER_ERR_CAPTURE_EN
   logic captured;

   always_ff @(posedge rd_clk_i or posedge a_rst_i) begin
      if (a_rst_i) begin
         captured    <= 1'b0;
         first_exp_o <= '0;
         first_act_o <= '0;
      end else if (mismatch && !captured) begin
         captured    <= 1'b1;
         first_exp_o <= exp_word;
         first_act_o <= rdata_i;
      end
   end
`else
   assign first_exp_o = '0;
   assign first_act_o = '0;
`endif

endmodule

// File: tb/tb_fifo_rd_checker.sv
// Self-checking bench for fifo_rd_checker: FIFO response model plus scoreboard
// predicting word/error counts and first-mismatch capture.
module tb_fifo_rd_checker;

   localparam logic [15:0] FIRST = 16'h0001;
`ifdef RD_CHECKER_ERR_CAPTURE_EN
   localparam bit CAP = 1'b1;
`else
   localparam bit CAP = 1'b0;
`endif

   logic        rd_clk_i = 1'b0;
   logic        a_rst_i = 1'b1;
   logic        enable_i = 1'b0;
   logic        pause_i = 1'b0;
   logic        rst_busy_i = 1'b0;
   logic        trigger_i = 1'b0;
   logic        empty_i = 1'b0;
   logic [31:0] rdata_i = '0;
   logic        rd_valid_i = 1'b0;
   logic        rd_en_o, busy_o, error_o, timeout_o;
   logic [15:0] err_count_o;
   logic [31:0] word_count_o, first_exp_o, first_act_o;

   fifo_rd_checker #(
      .FIRST_VALUE(FIRST), .BURST_LEN(16), .GAP_CYCLES(4), .TIMEOUT(64)
   ) dut (
      .rd_clk_i(rd_clk_i), .a_rst_i(a_rst_i), .enable_i(enable_i), .pause_i(pause_i),
      .rst_busy_i(rst_busy_i), .trigger_i(trigger_i), .empty_i(empty_i),
      .rdata_i(rdata_i), .rd_valid_i(rd_valid_i), .rd_en_o(rd_en_o), .busy_o(busy_o),
      .error_o(error_o), .timeout_o(timeout_o), .err_count_o(err_count_o),
      .word_count_o(word_count_o), .first_exp_o(first_exp_o), .first_act_o(first_act_o)
   );

   always #5 rd_clk_i = ~rd_clk_i;

   int n_checks = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   // FIFO source and reference model of the checker's counters
   logic [15:0] src_h;
   logic [15:0] m_exp;
   int          n_words, m_err, corrupt_idx;
   bit          m_first, rnd_corrupt, withhold, rd_en_seen;
   logic [31:0] m_fexp, m_fact;

   task automatic model_reset();
      src_h = FIRST; m_exp = FIRST; n_words = 0; m_err = 0;
      m_first = 0; m_fexp = '0; m_fact = '0; corrupt_idx = -1;
   endtask

   always @(posedge rd_clk_i) begin
      logic [31:0] word, expw;
      #1;
      if (rd_en_seen && !withhold) begin
         word  = {src_h, src_h + 16'd1};
         src_h = src_h + 16'd2;
         if (n_words == corrupt_idx) word = word ^ 32'h1;
         else if (rnd_corrupt && $urandom_range(7) == 0)
            word = word ^ (32'd1 << $urandom_range(31, 0));
         expw = {m_exp, m_exp + 16'd1};
         if (word != expw) begin
            if (m_err < 65535) m_err++;
            if (!m_first) begin m_first = 1; m_fexp = expw; m_fact = word; end
         end
         m_exp = m_exp + 16'd2;
         n_words++;
         rdata_i = word;
         rd_valid_i = 1'b1;
      end else begin
         rd_valid_i = 1'b0;
      end
   end

   // Burst shape monitor: a busy cycle without rd_en while nothing throttles is a gap cycle
   bit mon_on = 0;
   int en_cnt, gap_run, gaps_seen = 0;
   always @(negedge rd_clk_i) begin
      rd_en_seen = rd_en_o;
      if (mon_on) begin
         if (rd_en_o) begin
            if (gap_run > 0) begin
               chk("gap_len", gap_run, 4);
               gap_run = 0;
               gaps_seen++;
            end
            en_cnt++;
         end else if (busy_o && !empty_i && !pause_i && enable_i && !rst_busy_i) begin
            if (gap_run == 0) chk("burst_reads", en_cnt, 16);
            en_cnt = 0;
            gap_run++;
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin @(posedge rd_clk_i); #2; end
   endtask

   task automatic pulse_trigger();
      trigger_i = 1'b1; tick(1); trigger_i = 1'b0;
   endtask

   task automatic drain();
      empty_i = 1'b1; tick(4);
      @(negedge rd_clk_i);
   endtask

   task automatic do_reset();
      a_rst_i = 1'b1; model_reset(); tick(2); a_rst_i = 1'b0; tick(1);
   endtask

   task automatic chk_counts(input string tag);
      chk({tag, "_words"}, word_count_o, n_words);
      chk({tag, "_errcnt"}, {16'd0, err_count_o}, m_err);
      chk({tag, "_error"}, {31'd0, error_o}, {31'd0, m_err != 0});
   endtask

   initial begin
      int g0;
      model_reset();
      rnd_corrupt = 0; withhold = 0; rd_en_seen = 0;
      tick(2);
      @(negedge rd_clk_i);
      chk("rst_rd_en", {31'd0, rd_en_o}, 0);
      chk("rst_busy", {31'd0, busy_o}, 0);
      chk("rst_error", {31'd0, error_o}, 0);
      chk("rst_timeout", {31'd0, timeout_o}, 0);
      chk("rst_errcnt", {16'd0, err_count_o}, 0);
      chk("rst_words", word_count_o, 0);
      chk("rst_fexp", first_exp_o, 0);
      chk("rst_fact", first_act_o, 0);
      a_rst_i = 1'b0;

      // clean bursts, with an empty stretch and a pause pulse inside one burst
      enable_i = 1'b1; tick(3);
      @(negedge rd_clk_i);
      chk("arm_not_busy", {31'd0, busy_o}, 0);
      chk("arm_no_rd", {31'd0, rd_en_o}, 0);
      en_cnt = 0; gap_run = 0; mon_on = 1;
      pulse_trigger();
      @(negedge rd_clk_i);
      chk("first_read_cycle", {31'd0, rd_en_o}, 1);
      g0 = gaps_seen;
      for (int k = 0; k < 200 && gaps_seen == g0; k++) @(negedge rd_clk_i);
      chk("gap_observed", {31'd0, gaps_seen != g0}, 1);
      tick(3);
      empty_i = 1'b1; tick(10);
      empty_i = 1'b0; pause_i = 1'b1; tick(1);
      pause_i = 1'b0; tick(100);
      mon_on = 0;
      drain();
      chk_counts("clean");
      chk("clean_err0", {31'd0, error_o}, 0);

      // directed corruption of the third word, then random throttling and corruption
      do_reset();
      empty_i = 1'b0; corrupt_idx = 2;
      pulse_trigger(); tick(60);
      drain();
      chk_counts("inject");
      chk("inject_errcnt1", {16'd0, err_count_o}, 1);
      chk("inject_fexp", first_exp_o, CAP ? 32'h0005_0006 : 32'h0);
      chk("inject_fact", first_act_o, CAP ? 32'h0005_0007 : 32'h0);
      chk("model_fexp", first_exp_o, CAP ? m_fexp : 32'h0);
      corrupt_idx = -1; rnd_corrupt = 1;
      for (int k = 0; k < 400; k++) begin
         empty_i = ($urandom_range(3) == 0);
         pause_i = ($urandom_range(7) == 0);
         tick(1);
      end
      pause_i = 1'b0; rnd_corrupt = 0;
      drain();
      chk_counts("random");
      chk("random_fexp", first_exp_o, CAP ? 32'h0005_0006 : 32'h0);
      chk("random_fact", first_act_o, CAP ? m_fact : 32'h0);

      // rst_busy and enable drop mid-burst; late data still counted
      do_reset();
      empty_i = 1'b0;
      pulse_trigger(); tick(5);
      rst_busy_i = 1'b1;
      @(negedge rd_clk_i);
      chk("rstbusy_rd_en_now", {31'd0, rd_en_o}, 0);
      tick(1);
      @(negedge rd_clk_i);
      chk("rstbusy_idle", {31'd0, busy_o}, 0);
      chk("rstbusy_rd_en", {31'd0, rd_en_o}, 0);
      rst_busy_i = 1'b0; tick(3);
      @(negedge rd_clk_i);
      chk("rearm_waits_trigger", {31'd0, busy_o}, 0);
      chk_counts("rstbusy");
      pulse_trigger(); tick(4);
      enable_i = 1'b0; tick(1);
      @(negedge rd_clk_i);
      chk("disable_idle", {31'd0, busy_o | rd_en_o}, 0);
      tick(3);
      @(negedge rd_clk_i);
      chk_counts("late_data");
      enable_i = 1'b1;

      // timeout: two reads issued, no data returned
      do_reset();
      empty_i = 1'b1; withhold = 1;
      pulse_trigger(); tick(2);
      empty_i = 1'b0; tick(2);
      empty_i = 1'b1; tick(50);
      @(negedge rd_clk_i);
      chk("timeout_early", {31'd0, timeout_o}, 0);
      tick(20);
      @(negedge rd_clk_i);
      chk("timeout_set", {31'd0, timeout_o}, 1);
      chk("timeout_error", {31'd0, error_o}, 1);
      chk("timeout_errcnt", {16'd0, err_count_o}, 0);

      // async reset mid-burst
      withhold = 0; empty_i = 1'b0; tick(5);
      @(negedge rd_clk_i);
      chk("pre_arst_rd_en", {31'd0, rd_en_o}, 1);
      @(posedge rd_clk_i); #2;
      a_rst_i = 1'b1; model_reset();
      #1;
      chk("arst_rd_en", {31'd0, rd_en_o}, 0);
      chk("arst_busy", {31'd0, busy_o}, 0);
      chk("arst_error", {31'd0, error_o}, 0);
      chk("arst_timeout", {31'd0, timeout_o}, 0);
      chk("arst_errcnt", {16'd0, err_count_o}, 0);
      chk("arst_words", word_count_o, 0);
      chk("arst_fexp", first_exp_o, 0);
      chk("arst_fact", first_act_o, 0);
      tick(2); a_rst_i = 1'b0; tick(1);

      // long clean run across the 16-bit wrap of the expected sequence
      pulse_trigger();
      for (int k = 0; k < 45000 && n_words < 32770; k++) @(negedge rd_clk_i);
      chk("wrap_reached", {31'd0, n_words >= 32770}, 1);
      drain();
      chk_counts("wrap");
      chk("wrap_exp_next", {16'd0, m_exp}, {16'd0, FIRST + 16'(2 * (n_words - 32768))});

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/fifo_rd_checker.md
# fifo_rd_checker

Read-side traffic consumer and data checker for the asymmetric-width FIFO demo (16-bit write, 32-bit read). Sits directly downstream of the FIFO in the read clock domain: arms on the FIFO programmable-full flag, issues throttled burst reads gated by empty, and checks every valid read word against the incrementing 16-bit write sequence packed two-per-word. Reports sticky error, error count, word count and, optionally, the first mismatch.

## Interface
- FIRST_VALUE, 16'h0001, first 16-bit value written by the upstream generator
- BURST_LEN, 16, reads issued per burst; 0 = continuous (no GAP state)
- GAP_CYCLES, 4, idle cycles between bursts (≥1 when BURST_LEN≠0)
- TIMEOUT, 64, cycles with reads outstanding and no rd_valid before timeout error
- rd_clk_i  in  1  read clock; the block's only clock
- a_rst_i  in  1  asynchronous, active-high reset
- enable_i  in  1  level; 0 forces IDLE after the current cycle
- pause_i  in  1  level; suppresses rd_en without leaving the state
- rst_busy_i  in  1  FIFO reset-busy; high forces IDLE, no reads
- trigger_i  in  1  FIFO prog_full; arms reading
- empty_i  in  1  FIFO empty
- rdata_i  in  32  FIFO read data
- rd_valid_i  in  1  FIFO read-data valid
- rd_en_o  out  1  FIFO read enable
- busy_o  out  1  state is READ or GAP
- error_o  out  1  sticky: any mismatch or timeout
- timeout_o  out  1  sticky: timeout occurred
- err_count_o  out  16  mismatch count, saturates at 16'hFFFF
- word_count_o  out  32  valid words received, wraps
- first_exp_o  out  32  expected word of first mismatch
- first_act_o  out  32  actual word of first mismatch

## Operation
- All outputs reset to 0; expected half-word exp reset to FIRST_VALUE; state IDLE.
- States: IDLE → ARM when enable_i & ~rst_busy_i; ARM → READ when trigger_i; READ → GAP after BURST_LEN issued reads (BURST_LEN≠0); GAP → READ after GAP_CYCLES cycles. rst_busy_i or ~enable_i in any state → IDLE next cycle; checker counters, exp and sticky flags keep values (only a_rst_i clears them).
- Once armed, trigger_i is not re-checked; falling prog_full does not stop reading.
- rd_en_o = (state==READ) & ~empty_i & ~pause_i & enable_i & ~rst_busy_i, registered-free combinational from registered state. Burst counter increments only on cycles with rd_en_o=1.
- Check: on each rd_valid_i, expected word = {exp, exp+1} (earlier-written half in [31:16]); mismatch increments err_count_o (saturating) and sets error_o; exp advances by 2 modulo 2^16; word_count_o increments. Wrap: exp=16'hFFFF expects {16'hFFFF,16'h0000}, next exp=16'h0001.
- rd_valid_i is checked in every state, including IDLE (late data after disable is still checked).
- Outstanding counter (5-bit): +1 per rd_en_o, −1 per rd_valid_i, both same cycle → unchanged. Timeout counter runs while outstanding≠0 and rd_valid_i=0, clears otherwise; reaching TIMEOUT sets timeout_o and error_o, clears the counter.

## Timing
- rd_en_o asserted the first cycle state is READ (one cycle after the trigger_i sample in ARM).
- FIFO latency is not assumed; checking keys only on rd_valid_i.
- Counters/flags update on the rd_clk_i edge that samples rd_valid_i; visible next cycle.
- Empty asserted mid-burst: rd_en_o drops same cycle combinationally, burst count holds, resumes on ~empty_i.
- Async reset mid-burst: rd_en_o deasserts immediately (combinational from reset state).

## Configuration
- RD_CHECKER_ERR_CAPTURE_EN defined: first_exp_o/first_act_o latch expected/actual on the first mismatch after reset and hold thereafter.
- Not defined: capture registers omitted, first_exp_o/first_act_o tied to 32'h0; all other behaviour identical.

## Test plan
- Reset, enable_i=1, trigger_i pulse, FIFO model returns {0001,0002},{0003,0004},… → error_o=0, word_count_o=N, BURST_LEN=16 reads then 4 idle cycles repeated.
- Inject rdata_i=32'h0005_0007 where {0005,0006} expected → err_count_o=1, error_o=1, first_exp_o=32'h0005_0006, first_act_o=32'h0005_0007 (macro on) / 0 (macro off); next word {0007,0008} not counted as error.
- Sequence across wrap: {FFFF,0000} then {0001,0002} → no error.
- empty_i high for 10 cycles mid-burst, pause_i pulse → rd_en_o low those cycles, exactly 16 rd_en_o pulses per burst.
- Issue reads, withhold rd_valid_i 64 cycles → timeout_o=1, error_o=1, err_count_o unchanged.
- rst_busy_i high during READ → rd_en_o=0 next cycle, state IDLE; a_rst_i mid-burst → all outputs 0 immediately.
